multiplexor_display_bcd: RTL and testbench
==========================================

Name: multiplexor_display_bcd

Overview:
Scans four captured BCD digits onto the shared 4-bit input of the BCD-to-7-segment decoder. It drives the four common-anode digit enables, active-low, one digit at a time. It sits directly upstream of the decoder: Binario feeds the decoder's 4-bit input, and Anodos drives the display's anode transistors. Blanking uses code 4'hF, which the decoder maps to all-segments-off.

Parameters:
CICLOS_DIGITO, 50000, clock cycles each digit slot lasts (1 ms at 50 MHz); must be >= 2
CICLOS_APAGADO, 500, guard cycles at the start of each slot with all anodes off (anti-ghosting); 0 disables the guard; must be < CICLOS_DIGITO

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous, active-low reset
Carga  input  1  load strobe; captures Digitos on a rising edge
Digitos  input  16  four BCD digits; [3:0] = digit 0 (least significant) ... [15:12] = digit 3
SupresionCeros  input  1  1 = blank leading zeros
Habilitar  input  1  1 = scan active; 0 = display dark
Binario  output  4  digit code to the decoder; 4'hF = blank
Anodos  output  4  digit enables, active-low; bit i = digit i
FinBarrido  output  1  one-cycle pulse when the slot index wraps from 3 to 0

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - DigitosReg=16'h0, prescaler=0, indice=0.
  - Anodos=4'b1111, Binario=4'hF, FinBarrido=0.
- Capture:
  - Carga=1 at edge k loads DigitosReg at edge k.
  - Outputs reflect the new value from edge k+1.
  - Values >9 are stored and passed through unchanged; no checking is done.
- Prescaler:
  - While Habilitar=1, counts 0..CICLOS_DIGITO-1.
  - At terminal count it returns to 0 and indice advances modulo 4 (3 wraps to 0).
  - FinBarrido=1 in the cycle after the 3->0 advance.
- Outputs are registered, 1 cycle latency from {prescaler, indice, DigitosReg}.
  - Guard (prescaler < CICLOS_APAGADO): Anodos=4'b1111, Binario=4'hF.
  - Visible, digit i shown: Anodos = all ones except bit i = 0; Binario = DigitosReg[4i+3:4i].
  - Visible, digit i blanked: Anodos=4'b1111, Binario=4'hF.
- Leading-zero suppression (SupresionCeros=1):
  - Digit i (i=3..1) is blanked if DigitosReg digits 3 down to i are all 4'h0.
  - Digit 0 is never blanked.
  - A nonzero invalid code (A-F) counts as nonzero.
- Habilitar=0:
  - From the next edge: Anodos=4'b1111, Binario=4'hF, prescaler held at 0, indice held.
  - Carga is still honoured.
  - When Habilitar returns to 1, the held digit restarts a full slot, guard first.
- Simultaneous events:
  - Carga on a slot-boundary edge: the new slot shows the new data one cycle after the boundary.
  - The first visible cycle shows the new data when CICLOS_APAGADO >= 1.
- Reset mid-scan: outputs go dark immediately; scanning restarts at digit 0 with a guard after Rst_n rises.
- Slot sequence: 0,1,2,3,0,... A full sweep lasts 4*CICLOS_DIGITO cycles.
- Prescaler width is $clog2(CICLOS_DIGITO) with no overflow; the compare is exact equality to CICLOS_DIGITO-1.

Decomposition:
- Shared package/include holds constants: ANODOS_APAGADOS=4'b1111, BCD_BLANCO=4'hF, NUM_DIGITOS=4.
- The decoder owns its own segment constants; they are not shared here.
- One sub-module: divisor_tick. It is the parameterised prescaler with enable and synchronous clear, outputs the count and a terminal-count pulse, and is reusable by other timebase blocks.
- Indice, suppression logic and the output registers stay in the top level.

Test Plan:
(CICLOS_DIGITO=8, CICLOS_APAGADO=2)
1. Rst_n=0, then released with Habilitar=0 -> Anodos=4'b1111, Binario=4'hF, FinBarrido=0, held indefinitely.
2. Carga with Digitos=16'h1234, Habilitar=1, SupresionCeros=0 -> repeating per slot: 2 dark cycles, then 6 cycles of each of:
   - Binario=4 / Anodos=1110
   - Binario=3 / Anodos=1101
   - Binario=2 / Anodos=1011
   - Binario=1 / Anodos=0111
   FinBarrido pulses exactly once every 32 cycles.
3. SupresionCeros=1, Digitos=16'h0050 -> slots 3 and 2 dark (Anodos=1111, Binario=F); slot 1 shows 5, slot 0 shows 0. Digitos=16'h0000 -> only slot 0 shows 0. Digitos=16'h0A00 -> slot 2 shows A.
4. Habilitar dropped at cycle 4 of slot 2 -> next edge all dark, indice stays 2. Habilitar raised -> 2 guard cycles, then slot 2 for a full 6 visible cycles.
5. Carga with 16'h9876 on the same edge as the slot-1 boundary -> the first visible cycle of slot 1 shows Binario=7.
6. Rst_n asserted mid-visible slot -> Anodos=1111 and Binario=F before the next Clk edge; after release, scanning restarts at slot 0 with 2 guard cycles.

Source files
------------

// File: rtl/multiplexor_display_bcd_pkg.sv
// Shared constants and helpers for the BCD display multiplexer.
// The segment decoder keeps its own segment constants; only digit-level codes live here.
package multiplexor_display_bcd_pkg;

  localparam logic [3:0] ANODOS_APAGADOS = 4'b1111;
  localparam logic [3:0] BCD_BLANCO      = 4'hF;
  localparam int         NUM_DIGITOS     = 4;

  // A digit is a leading zero when it and every more significant digit are 4'h0.
  // Digit 0 is never a leading zero, so "0" still shows. Codes A-F count as nonzero.
  function automatic logic es_cero_izquierda(input logic [15:0] digitos,
                                             input logic [1:0]  indice);
    logic todo_cero;
    todo_cero = (indice != 2'd0);
    for (int j = 0; j < NUM_DIGITOS; j++) begin
      if ((j >= int'(indice)) && (digitos[4*j +: 4] != 4'h0)) todo_cero = 1'b0;
    end
    return todo_cero;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler with enable and synchronous clear.
// Counts 0..CICLOS-1 and flags the terminal count combinationally so the owner can act on the same edge.
module divisor_tick #(
  parameter int CICLOS = 50000,
  parameter int ANCHO  = $clog2(CICLOS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [ANCHO-1:0] cuenta,
  output logic             tick
);

  localparam logic [ANCHO-1:0] FIN = ANCHO'(CICLOS - 1);

  assign tick = en && !clr && (cuenta == FIN);

  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (en) begin
      cuenta <= tick ? '0 : cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/multiplexor_display_bcd.sv
// Scans four captured BCD digits onto the decoder input, driving active-low
// common-anode enables one slot at a time with an anti-ghosting guard per slot.
module multiplexor_display_bcd
  import multiplexor_display_bcd_pkg::*;
#(
  parameter int CICLOS_DIGITO  = 50000,
  parameter int CICLOS_APAGADO = 500
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Carga,
  input  logic [15:0] Digitos,
  input  logic        SupresionCeros,
  input  logic        Habilitar,
  output logic [3:0]  Binario,
  output logic [3:0]  Anodos,
  output logic        FinBarrido
);

  localparam int ANCHO = $clog2(CICLOS_DIGITO);

  logic [ANCHO-1:0] prescaler;
  logic             tick;
  logic [1:0]       indice;
  logic [15:0]      digitos_reg;
  logic             wrap_q;
  logic             guarda;
  logic             blanco;
  logic [3:0]       digito_actual;

  // Disabling clears the prescaler, so re-enabling restarts the held digit with a full slot.
  divisor_tick #(
    .CICLOS(CICLOS_DIGITO),
    .ANCHO (ANCHO)
  ) u_divisor_tick (
    .clk   (Clk),
    .rst_n (Rst_n),
    .en    (Habilitar),
    .clr   (!Habilitar),
    .cuenta(prescaler),
    .tick  (tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      digitos_reg <= 16'h0;
      indice      <= 2'd0;
      wrap_q      <= 1'b0;
    end else begin
      if (Carga) digitos_reg <= Digitos;
      if (tick)  indice      <= indice + 2'd1;
      wrap_q <= tick && (indice == 2'd3);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    guarda        = 1'b0;
    blanco        = 1'b0;
    digito_actual = digitos_reg[{indice, 2'b00} +: 4];
    guarda        = int'(prescaler) < CICLOS_APAGADO;
    blanco        = SupresionCeros && es_cero_izquierda(digitos_reg, indice);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Anodos     <= ANODOS_APAGADOS;
      Binario    <= BCD_BLANCO;
      FinBarrido <= 1'b0;
    end else begin
      if (!Habilitar || guarda || blanco) begin
        Anodos  <= ANODOS_APAGADOS;
        Binario <= BCD_BLANCO;
      end else begin
        Anodos  <= ~(4'b0001 << indice);
        Binario <= digito_actual;
      end
      FinBarrido <= Habilitar && wrap_q;
    end
  end

endmodule

// File: tb/tb_multiplexor_display_bcd.sv
// Self-checking bench for multiplexor_display_bcd with an 8-cycle slot and 2-cycle guard.
// The reference model tracks one sweep phase 0..31 and derives slot and position arithmetically.
module tb_multiplexor_display_bcd;

  localparam int CD = 8;
  localparam int CA = 2;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Carga = 1'b0;
  logic [15:0] Digitos = 16'h0;
  logic        SupresionCeros = 1'b0;
  logic        Habilitar = 1'b0;
  logic [3:0]  Binario;
  logic [3:0]  Anodos;
  logic        FinBarrido;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_digs = 16'h0;
  int          m_fase = 0;
  logic        m_wrap = 1'b0;
  logic [3:0]  e_an;
  logic [3:0]  e_bin;
  logic        e_fin;

  multiplexor_display_bcd #(
    .CICLOS_DIGITO (CD),
    .CICLOS_APAGADO(CA)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Carga         (Carga),
    .Digitos       (Digitos),
    .SupresionCeros(SupresionCeros),
    .Habilitar     (Habilitar),
    .Binario       (Binario),
    .Anodos        (Anodos),
    .FinBarrido    (FinBarrido)
  );

  always #5 Clk = ~Clk;

  // Predicts the outputs the coming edge will register, advances the model, then
  // waits for that edge and settles 1 time unit past it.
  task automatic step();
    int slot;
    int pos;
    slot = m_fase / CD;
    pos  = m_fase % CD;
    if (!Rst_n) begin
      e_an = 4'b1111; e_bin = 4'hF; e_fin = 1'b0;
      m_digs = 16'h0; m_fase = 0; m_wrap = 1'b0;
    end else begin
      e_fin = Habilitar && m_wrap;
      if (!Habilitar || pos < CA ||
          (SupresionCeros && slot > 0 && (m_digs >> (4 * slot)) == 16'h0)) begin
        e_an = 4'b1111; e_bin = 4'hF;
      end else begin
        e_an  = 4'b1111 ^ (4'b0001 << slot);
        e_bin = 4'((m_digs >> (4 * slot)) & 16'hF);
      end
      if (Carga) m_digs = Digitos;
      if (Habilitar) begin
        m_wrap = (m_fase == 4 * CD - 1);
        m_fase = (m_fase + 1) % (4 * CD);
      end else begin
        m_wrap = 1'b0;
        m_fase = slot * CD;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (Anodos !== 4'b1111 || Binario !== 4'hF || FinBarrido !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got an=%b bin=%h fin=%b, want an=1111 bin=f fin=0", Anodos, Binario, FinBarrido);
    end
    repeat (3) step();
    Rst_n = 1'b1;
    repeat (20) begin
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL reset_hold: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
    end
  endtask

  task automatic test_scan();
    int pulsos;
    int primero;
    int gap;
    pulsos = 0; primero = -1; gap = -1;
    Carga = 1'b1; Digitos = 16'h1234; Habilitar = 1'b1; SupresionCeros = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      Carga = 1'b0;
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL scan c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
      if (FinBarrido === 1'b1) begin
        pulsos++;
        if (primero < 0) primero = c; else if (gap < 0) gap = c - primero;
      end
    end
    n_cmp++;
    if (pulsos !== 2 || gap !== 32) begin
      n_err++;
      $display("FAIL scan_fin_period: got pulses=%0d gap=%0d, want pulses=2 gap=32", pulsos, gap);
    end
  endtask

  task automatic test_supresion();
    logic [15:0] pat [0:7];
    pat[0] = 16'h0050; pat[1] = 16'h0000; pat[2] = 16'h0A00;
    for (int p = 3; p < 8; p++) begin
      for (int d = 0; d < 4; d++)
        pat[p][4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    for (int p = 0; p < 8; p++) begin
      SupresionCeros = (p < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      Carga = 1'b1; Digitos = pat[p];
      for (int c = 0; c < 34; c++) begin
        step();
        Carga = 1'b0;
        n_cmp++;
        if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
          n_err++;
          $display("FAIL supr pat=%h c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", pat[p], c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
        end
      end
    end
  endtask

  task automatic test_habilitar();
    int vis;
    SupresionCeros = 1'b0;
    Carga = 1'b1; Digitos = 16'h4321;
    step();
    Carga = 1'b0;
    for (int k = 0; k < 64 && m_fase != 2 * CD + 4; k++) step();
    n_cmp++;
    if (m_fase != 2 * CD + 4) begin
      n_err++;
      $display("FAIL hab_reach: got phase=%0d, want %0d", m_fase, 2 * CD + 4);
    end
    Habilitar = 1'b0;
    repeat (5) begin
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL hab_off: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
    end
    Habilitar = 1'b1;
    vis = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL hab_on c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
      if (c < 2 && Anodos !== 4'b1111) begin
        n_err++;
        $display("FAIL hab_guard c=%0d: got an=%b, want an=1111", c, Anodos);
      end
      if (c < 2) n_cmp++;
      if (c < 8 && Anodos === 4'b1011 && Binario === 4'h3) vis++;
    end
    n_cmp++;
    if (vis !== 6) begin
      n_err++;
      $display("FAIL hab_slot2_len: got visible=%0d, want 6", vis);
    end
  endtask

  task automatic test_carga_limite();
    for (int k = 0; k < 64 && m_fase != CD - 1; k++) step();
    Carga = 1'b1; Digitos = 16'h9876;
    step();
    Carga = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL load_bound c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
      if (c == 2) begin
        n_cmp++;
        if (Anodos !== 4'b1101 || Binario !== 4'h7) begin
          n_err++;
          $display("FAIL load_bound_first: got an=%b bin=%h, want an=1101 bin=7", Anodos, Binario);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 64 && m_fase != CD + 5; k++) step();
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (Anodos !== 4'b1111 || Binario !== 4'hF || FinBarrido !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_async: got an=%b bin=%h fin=%b, want an=1111 bin=f fin=0", Anodos, Binario, FinBarrido);
    end
    repeat (2) step();
    Rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL reset_mid c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
      if (c == 2) begin
        n_cmp++;
        if (Anodos !== 4'b1110 || Binario !== 4'h0) begin
          n_err++;
          $display("FAIL reset_mid_restart: got an=%b bin=%h, want an=1110 bin=0", Anodos, Binario);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 200; c++) begin
      Carga = 1'($urandom_range(0, 7) == 0);
      Digitos = 16'($urandom);
      SupresionCeros = 1'($urandom_range(0, 1));
      Habilitar = 1'($urandom_range(0, 9) != 0);
      step();
      n_cmp++;
      if (Anodos !== e_an || Binario !== e_bin || FinBarrido !== e_fin) begin
        n_err++;
        $display("FAIL random c=%0d: got an=%b bin=%h fin=%b, want an=%b bin=%h fin=%b", c, Anodos, Binario, FinBarrido, e_an, e_bin, e_fin);
      end
    end
    Carga = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_supresion();
    test_habilitar();
    test_carga_limite();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
